// File: rtl/acc_cpu_param.sv
// acc_cpu_param: parametrised multi-cycle accumulator CPU.
// Each instruction takes three states (FETCH, DECODE, EXEC). Instructions and
// data share one memory, which is loaded through the prog_* port while idle.
// Optional feature macro: ACC_CPU_MUL_EN (opcode 0xD becomes MUL; otherwise NOP).
module acc_cpu_param #(
  parameter  int DATA_W  = 8,
  parameter  int ADDR_W  = 4,
  localparam int INSTR_W = DATA_W + 4,
  localparam int DEPTH   = 1 << ADDR_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               run,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_wdata,
  output logic [DATA_W-1:0]  acc,
  output logic [ADDR_W-1:0]  pc,
  output logic               zero,
  output logic               carry,
  output logic               busy,
  output logic               halted
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC} state_t;

  typedef struct packed {
    logic [3:0]        op;
    logic [DATA_W-1:0] opnd;
  } instr_t;

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_ST   = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_JZ   = 4'h8;
  localparam logic [3:0] OP_JC   = 4'h9;
  localparam logic [3:0] OP_LD   = 4'hA;
  localparam logic [3:0] OP_XOR  = 4'hB;
  localparam logic [3:0] OP_ADDI = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;
`ifdef ACC_CPU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'hD;
`endif

  logic [INSTR_W-1:0] mem [DEPTH];

  state_t            state;
  instr_t            ir;
  logic [DATA_W-1:0] mdr;
  logic [ADDR_W-1:0] addr;

  logic [DATA_W:0]   sum_m, sum_i, diff;
  logic [DATA_W-1:0] alu_res;
  logic              acc_we, carry_we, carry_nxt;
`ifdef ACC_CPU_MUL_EN
  logic [2*DATA_W-1:0] prod;
`endif

  assign addr = ir.opnd[ADDR_W-1:0];
  assign busy = (state != S_IDLE);

  // One extra bit on each operation captures carry-out / borrow.
  assign sum_m = {1'b0, acc} + {1'b0, mdr};
  assign sum_i = {1'b0, acc} + {1'b0, ir.opnd};
  assign diff  = {1'b0, acc} - {1'b0, mdr};
`ifdef ACC_CPU_MUL_EN
  assign prod  = acc * mdr;
`endif

  // ALU: result and flag-update enables for the instruction held in IR.
  always_comb begin
    alu_res   = acc;
    acc_we    = 1'b0;
    carry_we  = 1'b0;
    carry_nxt = carry;
    case (ir.op)
      OP_LDI:  begin alu_res = ir.opnd; acc_we = 1'b1; end
      OP_LD:   begin alu_res = mdr;     acc_we = 1'b1; end
      OP_ADD:  begin
        alu_res = sum_m[DATA_W-1:0]; acc_we = 1'b1;
        carry_nxt = sum_m[DATA_W]; carry_we = 1'b1;
      end
      OP_ADDI: begin
        alu_res = sum_i[DATA_W-1:0]; acc_we = 1'b1;
        carry_nxt = sum_i[DATA_W]; carry_we = 1'b1;
      end
      OP_SUB:  begin
        alu_res = diff[DATA_W-1:0]; acc_we = 1'b1;
        carry_nxt = diff[DATA_W]; carry_we = 1'b1;
      end
      OP_AND:  begin alu_res = acc & mdr; acc_we = 1'b1; end
      OP_OR:   begin alu_res = acc | mdr; acc_we = 1'b1; end
      OP_XOR:  begin alu_res = acc ^ mdr; acc_we = 1'b1; end
`ifdef ACC_CPU_MUL_EN
      OP_MUL:  begin
        alu_res = prod[DATA_W-1:0]; acc_we = 1'b1;
        carry_nxt = |prod[2*DATA_W-1:DATA_W]; carry_we = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Unified memory: program load while idle, STORE during EXEC. Not reset.
  // Reset forces state to IDLE asynchronously, so no STORE lands under reset.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && prog_we)
      mem[prog_addr] <= prog_wdata;
    else if (state == S_EXEC && ir.op == OP_ST)
      mem[addr] <= {4'h0, acc};
  end

  // Control FSM and architectural registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      pc     <= '0;
      acc    <= '0;
      zero   <= 1'b0;
      carry  <= 1'b0;
      halted <= 1'b0;
      ir     <= '0;
      mdr    <= '0;
    end else begin
      case (state)
        S_IDLE: if (run) begin
          state  <= S_FETCH;
          pc     <= '0;
          acc    <= '0;
          zero   <= 1'b0;
          carry  <= 1'b0;
          halted <= 1'b0;
        end
        S_FETCH: begin
          ir    <= mem[pc];
          pc    <= pc + ADDR_W'(1);
          state <= S_DECODE;
        end
        S_DECODE: begin
          mdr   <= mem[addr][DATA_W-1:0];
          state <= S_EXEC;
        end
        S_EXEC: begin
          state <= S_FETCH;
          if (acc_we) begin
            acc  <= alu_res;
            zero <= (alu_res == '0);
          end
          if (carry_we) carry <= carry_nxt;
          case (ir.op)
            OP_JMP:  pc <= addr;
            OP_JZ:   if (zero)  pc <= addr;
            OP_JC:   if (carry) pc <= addr;
            OP_HALT: begin halted <= 1'b1; state <= S_IDLE; end
            default: ;
          endcase
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_cpu_param.sv
// Directed bench for acc_cpu_param (DATA_W=8, ADDR_W=4). Expected values are
// hand-computed from the instruction set; timing follows 3 edges/instruction.
module tb_acc_cpu_param;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int INSTR_W = DATA_W + 4;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               run = 1'b0;
  logic               prog_we = 1'b0;
  logic [ADDR_W-1:0]  prog_addr = '0;
  logic [INSTR_W-1:0] prog_wdata = '0;
  logic [DATA_W-1:0]  acc;
  logic [ADDR_W-1:0]  pc;
  logic               zero, carry, busy, halted;

  int checks = 0;
  int errors = 0;

  acc_cpu_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata), .acc(acc), .pc(pc),
    .zero(zero), .carry(carry), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; inputs/samples sit 1 time unit after the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] d);
    prog_we = 1'b1; prog_addr = a; prog_wdata = d;
    tick();
    prog_we = 1'b0;
  endtask

  // The run edge itself is edge 0 of the program.
  task automatic start();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_acc", acc, 0);   chk("rst_pc", pc, 0);
    chk("rst_zero", zero, 0); chk("rst_carry", carry, 0);
    chk("rst_busy", busy, 0); chk("rst_halted", halted, 0);
    tick(2);
    reset_n = 1'b1;
    tick();

    // 1: LDI F0, ADD [8]=0x20 -> 0x110, HALT
    load(4'h0, 12'h1F0); load(4'h1, 12'h208); load(4'h2, 12'hF00); load(4'h8, 12'h020);
    start();
    tick(8);
    chk("t1_busy_e8", busy, 1); chk("t1_halted_e8", halted, 0);
    tick();
    chk("t1_acc", acc, 8'h10); chk("t1_carry", carry, 1); chk("t1_zero", zero, 0);
    chk("t1_halted", halted, 1); chk("t1_busy", busy, 0);

    // 2: LDI 5, SUB [9]=5 -> 0, JZ 6 skipping LDI FF at 3..5, HALT at 6
    load(4'h0, 12'h105); load(4'h1, 12'h309); load(4'h2, 12'h806);
    load(4'h3, 12'h1FF); load(4'h4, 12'h1FF); load(4'h5, 12'h1FF);
    load(4'h6, 12'hF00); load(4'h9, 12'h005);
    start();
    chk("t2_halt_clr", halted, 0);
    tick(12);
    chk("t2_acc", acc, 0); chk("t2_zero", zero, 1); chk("t2_carry", carry, 0);
    chk("t2_pc", pc, 7); chk("t2_halted", halted, 1);

    // 3: LDI A5, STORE [C], LDI 0, LD [C], HALT; mem0 written in the run cycle
    load(4'h1, 12'h60C); load(4'h2, 12'h100); load(4'h3, 12'hA0C); load(4'h4, 12'hF00);
    prog_we = 1'b1; prog_addr = 4'h0; prog_wdata = 12'h1A5; run = 1'b1;
    tick();
    prog_we = 1'b0; run = 1'b0;
    tick(15);
    chk("t3_acc", acc, 8'hA5); chk("t3_zero", zero, 0); chk("t3_halted", halted, 1);
    chk("t3_mem12", dut.mem[12], 12'h0A5);

    // 4: tight loop LDI 33 / JMP 1; busy write ignored; reset in DECODE; rerun
    load(4'h0, 12'h133); load(4'h1, 12'h701); load(4'hA, 12'h0AA);
    start();
    tick();
    prog_we = 1'b1; prog_addr = 4'hA; prog_wdata = 12'h555;
    tick();
    prog_we = 1'b0;
    tick(2);                       // edge 4: instr 2 fetched, now in DECODE
    chk("t4_acc_pre", acc, 8'h33); chk("t4_pc_pre", pc, 2); chk("t4_busy_pre", busy, 1);
    chk("t4_mem10", dut.mem[10], 12'h0AA);
    reset_n = 1'b0;
    #1;
    chk("t4_rst_acc", acc, 0); chk("t4_rst_pc", pc, 0); chk("t4_rst_busy", busy, 0);
    tick();
    reset_n = 1'b1;
    load(4'h1, 12'hF00);
    start();
    tick(6);
    chk("t4_rerun_acc", acc, 8'h33); chk("t4_rerun_pc", pc, 2);
    chk("t4_rerun_halted", halted, 1);

    // 5: JMP E, STORE [0] (turns mem0 into NOP), LDI 1 at 15, wrap, NOP, HALT at 1
    load(4'h0, 12'h70E); load(4'hE, 12'h600); load(4'hF, 12'h101); load(4'h1, 12'hF00);
    start();
    tick(7);                       // LDI at 15 fetched
    chk("t5_pc_wrap", pc, 0);
    tick(8);
    chk("t5_acc", acc, 8'h01); chk("t5_halted", halted, 1); chk("t5_pc", pc, 2);
    chk("t5_mem0", dut.mem[0], 12'h000);

    // 6: LDI 20, op D with M=[A]=0x10, HALT
    load(4'h0, 12'h120); load(4'h1, 12'hD0A); load(4'h2, 12'hF00); load(4'hA, 12'h010);
    start();
    tick(9);
    chk("t6_halted", halted, 1);
`ifdef ACC_CPU_MUL_EN
    chk("t6_acc", acc, 8'h00); chk("t6_carry", carry, 1); chk("t6_zero", zero, 1);
`else
    chk("t6_acc", acc, 8'h20); chk("t6_carry", carry, 0); chk("t6_zero", zero, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
